mac_result_collector: RTL and testbench
=======================================

# mac_result_collector

Downstream stage of `mac_array`. It captures each lane's `acc_out_*` on the rising edge of that lane's `valid_out` bit and assembles the lanes into complete rows. Completed rows are buffered in a small row FIFO and streamed out one lane per beat over a valid/ready interface. It decouples the array's strobe-timed results from a back-pressured consumer, such as a writeback or next-layer feeder.

## Interface
- `ACC_W`, 16, accumulator and output data width (signed).
- `N_MACS`, 4, number of lanes per row. Ports below are shown for N_MACS=4.
- `DEPTH`, 4, row FIFO depth in rows. Must be a power of two and at least 2.
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  reset, asynchronous and active-low. All state clears while `rst`=0.
- `clear`  in  1  synchronous flush of the assembly row, FIFO, stream FSM and `overflow`.
- `acc_out_0..acc_out_3`  in  ACC_W each  lane results from `mac_array`.
- `valid_out`  in  N_MACS  per-lane result-valid levels from `mac_array`.
- `out_data`  out  ACC_W  streamed lane value.
- `out_lane`  out  clog2(N_MACS)  lane index of the current beat.
- `out_last`  out  1  high on the beat carrying lane N_MACS-1.
- `out_valid`  out  1  beat is valid.
- `out_ready`  in  1  consumer accepts the beat.
- `rows_avail`  out  clog2(DEPTH)+1  number of complete rows in the FIFO.
- `overflow`  out  1  sticky flag: a sample was dropped.

## Operation
- **Edge detect.** `valid_prev` registers `valid_out`. A lane is captured when `valid_out[i] & ~valid_prev[i]`. A level held high does not recapture.
- **Assembly row.** The row holds N_MACS data registers plus a `filled` mask, and lanes fill in any order.
  - When a rising edge arrives on a lane whose `filled` bit is already set, the sample is dropped and `overflow` is set.
- **Row push.** When `filled` is all ones and the FIFO is not full, the row is pushed on the next clock and `filled` clears.
  - A capture in the same cycle as a push lands in the fresh row, so no sample is lost.
  - If the FIFO is full, the row holds. Further rising edges on the filled lanes are dropped and set `overflow`.
- **FIFO.** DEPTH×N_MACS×ACC_W storage with wrapping read and write pointers.
  - A push and a pop in the same cycle are both legal, including when the FIFO is full (the pop frees the slot).
- **Stream FSM.**
  - IDLE → STREAM when `rows_avail`≠0. Lane counter = 0, `out_valid`=1.
  - In STREAM, each `out_valid&out_ready` advances the lane counter.
  - On the last beat the FIFO pops. The FSM then goes to IDLE, or stays in STREAM with the counter at 0 if another row is available. There are no bubbles between rows.
  - `out_data`, `out_lane` and `out_last` are stable while `out_valid`=1 and `out_ready`=0.
- **Data.** Values pass through unmodified as signed ACC_W. No arithmetic is performed.
- **`clear`.** Has priority over capture, push and pop in its cycle. `valid_prev` still updates, so a level held through `clear` does not recapture.

## Timing
- **Reset values.** `out_data`=0, `out_lane`=0, `out_last`=0, `out_valid`=0, `rows_avail`=0, `overflow`=0. Also `filled`=0, `valid_prev`=0, FSM=IDLE.
- **Latency.** The rising edge of the last lane is sampled at edge T, and the lane register is written at T. The row is pushed at T+1, making `rows_avail` 1 after T+1. `out_valid` is high after T+2.
- **Throughput.** One beat per cycle with `out_ready`=1, so N_MACS cycles per row.
- **Reset mid-stream.** `out_valid` drops immediately (asynchronously). A partially streamed row is lost.
- **`overflow`.** Registered, asserted the cycle after the dropped edge. It clears only on reset or `clear`.

## Structure
- Package `systolic_pkg`:
  - constant `LANE_W` = clog2(N_MACS)
  - enum `stream_state_t` {IDLE, STREAM}
  - typedef for the packed row (N_MACS×ACC_W).
- Sub-module `row_fifo` (parameters DEPTH and row width): push/pop/full/empty/count. The collector holds the edge detect, assembly and stream FSM.

## Test plan
- **Single row.** Stimulus: N_MACS=4, `a_in`=10, `w`={2,3,0,0}, valid edges on lanes 0–3 staggered one cycle apart, `out_ready`=1. Required: beats 20, 30, 0, 0 with lanes 0–3. `out_last` is high on the 4th beat only. First `out_valid` comes 2 cycles after the lane-3 edge.
- **Back-pressure.** Stimulus: two rows ({20,30,0,0}, then `a_in`=5 giving {10,15,0,0}), `out_ready` toggling 1/0. Required: exactly 8 beats in order, and data is stable during stalls.
- **FIFO full.** Stimulus: `out_ready`=0, push DEPTH+1 rows. Required: `rows_avail`=4. The 5th row holds in assembly. A 6th edge on lane 0 sets `overflow`. After raising `out_ready`, 5 rows (20 beats) drain.
- **Simultaneous push/pop at full.** Stimulus: FIFO full, the last beat is accepted in the same cycle a row completes. Required: `rows_avail` stays 4 and `overflow` stays 0.
- **Reset/clear mid-stream.** Stimulus: pulse `rst`=0 on beat 2 of a row, and separately assert `clear` with 1 row queued. Required: outputs at their reset values, `rows_avail`=0, and no beats afterwards until new edges arrive.
- **Held level.** Stimulus: `valid_out[0]` held high for 5 cycles. Required: lane 0 captures only once and `overflow` stays 0.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared types and constants for the systolic array result path.
package systolic_pkg;
    localparam int ACC_W_DEF  = 16;
    localparam int N_MACS_DEF = 4;
    localparam int LANE_W     = $clog2(N_MACS_DEF);

    typedef enum logic {IDLE, STREAM} stream_state_t;

    typedef logic signed [N_MACS_DEF-1:0][ACC_W_DEF-1:0] row_t;
endpackage

// File: rtl/row_fifo.sv
// Row-wide FIFO with wrapping pointers; a push into a full FIFO is accepted
// when a pop happens in the same cycle.
module row_fifo #(
    parameter int DEPTH = 4,
    parameter int ROW_W = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [ROW_W-1:0]         wr_row,
    output logic [ROW_W-1:0]         rd_row,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [ROW_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign count   = cnt;
    assign rd_row  = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr] <= wr_row;
    end
endmodule

// File: rtl/mac_result_collector.sv
// Captures mac_array lane results on valid rising edges, assembles rows,
// queues them and streams one lane per beat over valid/ready.
module mac_result_collector
    import systolic_pkg::*;
#(
    parameter int ACC_W  = ACC_W_DEF,
    parameter int N_MACS = N_MACS_DEF,
    parameter int DEPTH  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear,
    input  logic signed [ACC_W-1:0]   acc_out_0,
    input  logic signed [ACC_W-1:0]   acc_out_1,
    input  logic signed [ACC_W-1:0]   acc_out_2,
    input  logic signed [ACC_W-1:0]   acc_out_3,
    input  logic [N_MACS-1:0]         valid_out,
    output logic signed [ACC_W-1:0]   out_data,
    output logic [LANE_W-1:0]         out_lane,
    output logic                      out_last,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [$clog2(DEPTH):0]    rows_avail,
    output logic                      overflow
);
    localparam int ROW_W = N_MACS * ACC_W;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(N_MACS - 1);

    logic signed [ACC_W-1:0] lane_in [N_MACS];
    logic signed [ACC_W-1:0] row_data_p0 [N_MACS];
    logic [N_MACS-1:0]       valid_prev;
    logic [N_MACS-1:0]       filled;
    logic [N_MACS-1:0]       rise, avail, cap, drop, filled_nxt;
    logic [ROW_W-1:0]        wr_row, rd_row;
    logic                    push, pop, fifo_full, fifo_empty;
    stream_state_t           state_q, state_nxt;
    logic [LANE_W-1:0]       lane_q, lane_nxt;

    assign lane_in[0] = acc_out_0;
    assign lane_in[1] = acc_out_1;
    assign lane_in[2] = acc_out_2;
    assign lane_in[3] = acc_out_3;

    // Edge detect and assembly row; a pushing row frees every lane for this cycle's captures
    always_comb begin
        rise       = valid_out & ~valid_prev;
        push       = (&filled) && (!fifo_full || pop) && !clear;
        avail      = push ? '0 : filled;
        cap        = rise & ~avail & {N_MACS{!clear}};
        drop       = rise & avail & {N_MACS{!clear}};
        filled_nxt = avail | cap;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_prev <= '0;
            filled     <= '0;
            overflow   <= 1'b0;
        end else begin
            valid_prev <= valid_out;
            if (clear) begin
                filled   <= '0;
                overflow <= 1'b0;
            end else begin
                filled   <= filled_nxt;
                overflow <= overflow | (|drop);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < N_MACS; i++) begin
            if (cap[i]) row_data_p0[i] <= lane_in[i];
        end
    end

    always_comb begin
        wr_row = '0;
        for (int i = 0; i < N_MACS; i++) wr_row[i*ACC_W +: ACC_W] = row_data_p0[i];
    end

    // Row FIFO stage
    row_fifo #(.DEPTH(DEPTH), .ROW_W(ROW_W)) u_row_fifo (
        .clk    (clk),
        .rst    (rst),
        .clear  (clear),
        .push   (push),
        .pop    (pop),
        .wr_row (wr_row),
        .rd_row (rd_row),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (rows_avail)
    );

    // Stream stage
    assign pop = (state_q == STREAM) && out_ready && (lane_q == LAST_LANE)
                 && !fifo_empty && !clear;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            lane_q  <= '0;
        end else begin
            state_q <= state_nxt;
            lane_q  <= lane_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        lane_nxt  = lane_q;
        if (clear) begin
            state_nxt = IDLE;
            lane_nxt  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rows_avail != '0) begin
                        state_nxt = STREAM;
                        lane_nxt  = '0;
                    end
                end
                STREAM: begin
                    if (out_ready) begin
                        if (lane_q == LAST_LANE) begin
                            lane_nxt = '0;
                            if (rows_avail <= CW'(1)) state_nxt = IDLE;
                        end else begin
                            lane_nxt = lane_q + LANE_W'(1);
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign out_valid = (state_q == STREAM);
    assign out_lane  = lane_q;
    assign out_last  = out_valid && (lane_q == LAST_LANE);
    assign out_data  = out_valid ? $signed(rd_row[int'(lane_q)*ACC_W +: ACC_W]) : '0;
endmodule

// File: tb/tb_mac_result_collector.sv
// Directed bench for mac_result_collector: row assembly, streaming,
// back-pressure, FIFO full, reset/clear and held valid levels.
module tb_mac_result_collector;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic clear = 1'b0;
    logic signed [15:0] a0 = '0, a1 = '0, a2 = '0, a3 = '0;
    logic [3:0] valid_out = '0;
    logic out_ready = 1'b0;
    logic signed [15:0] out_data;
    logic [1:0] out_lane;
    logic out_last, out_valid, overflow;
    logic [2:0] rows_avail;

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    mac_result_collector #(.ACC_W(16), .N_MACS(4), .DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .acc_out_0  (a0),
        .acc_out_1  (a1),
        .acc_out_2  (a2),
        .acc_out_3  (a3),
        .valid_out  (valid_out),
        .out_data   (out_data),
        .out_lane   (out_lane),
        .out_last   (out_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .rows_avail (rows_avail),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load_row(input int v0, input int v1, input int v2, input int v3);
        a0 = 16'(v0); a1 = 16'(v1); a2 = 16'(v2); a3 = 16'(v3);
        exp_q.push_back(v0); exp_q.push_back(v1);
        exp_q.push_back(v2); exp_q.push_back(v3);
    endtask

    task automatic fire_all;
        valid_out = 4'hF;
        tick();
        valid_out = 4'h0;
        tick();
    endtask

    task automatic drain(input int n, input bit toggle);
        int idx = 0;
        int cyc = 0;
        bit held = 0;
        int hd = 0;
        int hl = 0;
        int e;
        while (idx < n && cyc < 400) begin
            out_ready = toggle ? (cyc % 2 == 0) : 1'b1;
            if (held) begin
                check("stall_valid", int'(out_valid), 1);
                check("stall_data", int'(out_data), hd);
                check("stall_lane", int'(out_lane), hl);
                held = 0;
            end
            if (out_valid) begin
                if (out_ready) begin
                    e = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
                    check("beat_data", int'(out_data), e);
                    check("beat_lane", int'(out_lane), idx % 4);
                    check("beat_last", int'(out_last), (idx % 4 == 3) ? 1 : 0);
                    idx++;
                end else begin
                    held = 1;
                    hd = int'(out_data);
                    hl = int'(out_lane);
                end
            end
            tick();
            cyc++;
        end
        out_ready = 1'b0;
        if (idx < n) check("drain_timeout", idx, n);
    endtask

    initial begin
        tick();
        tick();
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_out_lane", int'(out_lane), 0);
        check("rst_out_last", int'(out_last), 0);
        check("rst_rows_avail", int'(rows_avail), 0);
        check("rst_overflow", int'(overflow), 0);
        rst = 1'b1;
        tick();

        // single row, staggered edges, latency
        load_row(20, 30, 0, 0);
        for (int i = 0; i < 4; i++) begin
            valid_out = 4'(1 << i);
            tick();
        end
        valid_out = 4'h0;
        check("lat_T_rows", int'(rows_avail), 0);
        check("lat_T_valid", int'(out_valid), 0);
        tick();
        check("lat_T1_rows", int'(rows_avail), 1);
        check("lat_T1_valid", int'(out_valid), 0);
        tick();
        check("lat_T2_valid", int'(out_valid), 1);
        drain(4, 0);
        tick();
        check("single_idle", int'(out_valid), 0);
        check("single_rows", int'(rows_avail), 0);

        // back-pressure, two rows
        load_row(20, 30, 0, 0);
        fire_all();
        load_row(10, 15, 0, 0);
        fire_all();
        drain(8, 1);
        tick();
        check("bp_idle", int'(out_valid), 0);
        check("bp_rows", int'(rows_avail), 0);

        // FIFO full, fifth row holds, sixth edge overflows
        for (int r = 1; r <= 4; r++) begin
            load_row(r * 100, r * 100 + 1, r * 100 + 2, -(r * 100 + 3));
            fire_all();
        end
        check("full_rows", int'(rows_avail), 4);
        load_row(500, 501, 502, -503);
        fire_all();
        tick();
        check("full_hold_rows", int'(rows_avail), 4);
        check("full_hold_ovf", int'(overflow), 0);
        valid_out = 4'h1;
        tick();
        valid_out = 4'h0;
        check("full_ovf_set", int'(overflow), 1);
        drain(20, 0);
        tick();
        check("full_drained", int'(rows_avail), 0);
        check("full_ovf_sticky", int'(overflow), 1);

        // clear, then simultaneous push/pop at full
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_ovf", int'(overflow), 0);
        for (int r = 1; r <= 4; r++) begin
            load_row(r, r + 10, r + 20, r + 30);
            fire_all();
        end
        check("pp_full", int'(rows_avail), 4);
        load_row(-7, 8, -9, 10);
        out_ready = 1'b1;
        tick();
        tick();
        check("pp_lane2", int'(out_lane), 2);
        valid_out = 4'hF;
        tick();
        valid_out = 4'h0;
        check("pp_lane3", int'(out_lane), 3);
        tick();
        out_ready = 1'b0;
        check("pp_rows", int'(rows_avail), 4);
        check("pp_ovf", int'(overflow), 0);
        for (int i = 0; i < 4; i++) void'(exp_q.pop_front());
        drain(16, 0);
        tick();
        check("pp_drained", int'(rows_avail), 0);

        // asynchronous reset mid-stream
        load_row(1, 2, 3, 4);
        fire_all();
        tick();
        out_ready = 1'b1;
        tick();
        tick();
        check("mid_lane2", int'(out_lane), 2);
        rst = 1'b0;
        #1;
        check("arst_valid", int'(out_valid), 0);
        check("arst_data", int'(out_data), 0);
        check("arst_lane", int'(out_lane), 0);
        check("arst_last", int'(out_last), 0);
        check("arst_rows", int'(rows_avail), 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        tick(); tick(); tick();
        check("arst_no_beats", int'(out_valid), 0);
        out_ready = 1'b0;

        // clear with one row queued
        load_row(5, 6, 7, 8);
        fire_all();
        check("clr_q_rows", int'(rows_avail), 1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_valid", int'(out_valid), 0);
        check("clr_rows", int'(rows_avail), 0);
        check("clr_lane", int'(out_lane), 0);
        exp_q.delete();
        out_ready = 1'b1;
        tick(); tick(); tick(); tick();
        check("clr_no_beats", int'(out_valid), 0);
        out_ready = 1'b0;

        // held level on lane 0
        load_row(77, 1, 2, 3);
        valid_out = 4'h1;
        tick();
        a0 = 16'sd99;
        tick(); tick(); tick(); tick();
        valid_out = 4'h3;
        tick();
        valid_out = 4'h7;
        tick();
        valid_out = 4'hF;
        tick();
        valid_out = 4'h0;
        tick();
        tick();
        check("held_rows", int'(rows_avail), 1);
        check("held_ovf", int'(overflow), 0);
        drain(4, 0);
        tick();
        check("held_drained", int'(rows_avail), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
